// File: rtl/regfile_write_queue.sv
// regfile_write_queue: buffers register writeback requests and drains them,
// one per cycle, into the register file's single write port. Pending writes
// are forwarded to both read ports so reads never see stale data. Writes to
// register 0 are accepted and dropped.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   wb_valid/addr/data      writeback request from the pipeline
//   wb_ready                queue can accept a request this cycle
//   drain_en                register file write port available this cycle
//   write_en/write_reg_*    register file write port (head entry)
//   read_reg_{a,b}_addr     addresses currently read from the register file
//   fwd_{a,b}_hit/data      newest queued value overriding the register file
//   count                   occupied entries
module regfile_write_queue #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned REG_SIZE      = 32,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]   wb_addr,
  input  logic [REG_SIZE-1:0]        wb_data,
  output logic                       wb_ready,
  input  logic                       drain_en,
  output logic                       write_en,
  output logic [ADDRESS_WIDTH-1:0]   write_reg_addr,
  output logic [REG_SIZE-1:0]        write_reg_data_in,
  input  logic [ADDRESS_WIDTH-1:0]   read_reg_a_addr,
  input  logic [ADDRESS_WIDTH-1:0]   read_reg_b_addr,
  output logic                       fwd_a_hit,
  output logic                       fwd_b_hit,
  output logic [REG_SIZE-1:0]        fwd_a_data,
  output logic [REG_SIZE-1:0]        fwd_b_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [REG_SIZE-1:0]      data_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic accept;
  logic enq;
  logic deq;

  // Handshake and drain are driven from registered state plus drain_en only.
  assign wb_ready = (count_q < CNT_W'(DEPTH));
  assign write_en = (count_q != '0) && drain_en;
  assign accept   = wb_valid && wb_ready;
  assign enq      = accept && (wb_addr != '0);
  assign deq      = write_en;
  assign count    = count_q;

  // Head entry is masked to zero when the queue is empty.
  assign write_reg_addr    = (count_q != '0) ? addr_q[head_q] : '0;
  assign write_reg_data_in = (count_q != '0) ? data_q[head_q] : '0;

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail_q] <= wb_addr;
      data_q[tail_q] <= wb_data;
    end
  end

  // Forwarding: walk oldest to newest so the newest match overwrites.
  // The head entry still counts while it is being drained this cycle.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((read_reg_a_addr != '0) && (addr_q[idx] == read_reg_a_addr)) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = data_q[idx];
        end
        if ((read_reg_b_addr != '0) && (addr_q[idx] == read_reg_b_addr)) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Testbench for regfile_write_queue: directed steps with a scoreboard of
// pending writes that predicts drain order, occupancy and forwarding.
module tb_regfile_write_queue;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          drain_en;
  logic          write_en;
  logic [AW-1:0] write_reg_addr;
  logic [DW-1:0] write_reg_data_in;
  logic [AW-1:0] read_reg_a_addr;
  logic [AW-1:0] read_reg_b_addr;
  logic          fwd_a_hit;
  logic          fwd_b_hit;
  logic [DW-1:0] fwd_a_data;
  logic [DW-1:0] fwd_b_data;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  regfile_write_queue #(
    .ADDRESS_WIDTH(AW),
    .REG_SIZE(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_ready(wb_ready),
    .drain_en(drain_en),
    .write_en(write_en),
    .write_reg_addr(write_reg_addr),
    .write_reg_data_in(write_reg_data_in),
    .read_reg_a_addr(read_reg_a_addr),
    .read_reg_b_addr(read_reg_b_addr),
    .fwd_a_hit(fwd_a_hit),
    .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data),
    .fwd_b_data(fwd_b_data),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending write to a nonzero address wins.
  task automatic fwd_model(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == a) begin
          hit = 1'b1;
          d   = exp_q[i].data;
        end
      end
    end
  endtask

  // One clock cycle: compare DUT against the scoreboard, then apply the edge.
  task automatic cyc();
    logic          hit;
    logic [DW-1:0] fd;
    logic          exp_we;
    #1;
    exp_we = drain_en && (exp_q.size() != 0);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("wb_ready", 64'(wb_ready), 64'(exp_q.size() < DEPTH));
    chk("write_en", 64'(write_en), 64'(exp_we));
    if (exp_q.size() != 0) begin
      chk("wr_addr", 64'(write_reg_addr), 64'(exp_q[0].addr));
      chk("wr_data", 64'(write_reg_data_in), 64'(exp_q[0].data));
    end else begin
      chk("wr_addr_idle", 64'(write_reg_addr), 64'(0));
      chk("wr_data_idle", 64'(write_reg_data_in), 64'(0));
    end
    fwd_model(read_reg_a_addr, hit, fd);
    chk("fwd_a_hit", 64'(fwd_a_hit), 64'(hit));
    chk("fwd_a_data", 64'(fwd_a_data), 64'(fd));
    fwd_model(read_reg_b_addr, hit, fd);
    chk("fwd_b_hit", 64'(fwd_b_hit), 64'(hit));
    chk("fwd_b_data", 64'(fwd_b_data), 64'(fd));
    // Edge effects: accept is judged on the pre-edge occupancy.
    if (wb_valid && (exp_q.size() < DEPTH) && (wb_addr != '0)) begin
      if (exp_we) void'(exp_q.pop_front());
      exp_q.push_back('{addr: wb_addr, data: wb_data});
    end else if (exp_we) begin
      void'(exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    cyc();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    wb_valid        = 1'b0;
    wb_addr         = '0;
    wb_data         = '0;
    drain_en        = 1'b0;
    read_reg_a_addr = '0;
    read_reg_b_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;

    // Reset state and idle drain
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_wb_ready", 64'(wb_ready), 64'(1));
    chk("rst_write_en", 64'(write_en), 64'(0));
    chk("rst_fwd_a_hit", 64'(fwd_a_hit), 64'(0));
    drain_en = 1'b1;
    repeat (3) cyc();

    // Single write then drain
    drain_en        = 1'b0;
    read_reg_a_addr = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    #1;
    chk("single_count", 64'(count), 64'(1));
    chk("single_fwd_hit", 64'(fwd_a_hit), 64'(1));
    chk("single_fwd_data", 64'(fwd_a_data), 64'hDEADBEEF);
    drain_en = 1'b1;
    #1;
    chk("single_we", 64'(write_en), 64'(1));
    chk("single_wdata", 64'(write_reg_data_in), 64'hDEADBEEF);
    cyc();
    #1;
    chk("single_we_after", 64'(write_en), 64'(0));
    chk("single_fwd_after", 64'(fwd_a_hit), 64'(0));
    cyc();

    // Fill to full, newest-wins forwarding, rejected fifth request, ordered drain
    drain_en        = 1'b0;
    read_reg_b_addr = 5'd3;
    push(5'd3, 32'd1);
    push(5'd4, 32'd2);
    push(5'd3, 32'd3);
    push(5'd7, 32'd4);
    #1;
    chk("full_count", 64'(count), 64'(4));
    chk("full_wb_ready", 64'(wb_ready), 64'(0));
    chk("full_fwd_b", 64'(fwd_b_data), 64'(3));
    push(5'd9, 32'd5);
    drain_en = 1'b1;
    repeat (5) cyc();

    // Register 0 is accepted and dropped, and never forwards
    read_reg_a_addr = 5'd0;
    push(5'd0, 32'h1234);
    repeat (2) cyc();
    chk("r0_count", 64'(count), 64'(0));
    chk("r0_fwd_hit", 64'(fwd_a_hit), 64'(0));

    // Back-to-back push and pop across pointer wrap
    read_reg_a_addr = 5'd4;
    for (int i = 1; i <= 10; i++) begin
      wb_valid = 1'b1;
      wb_addr  = AW'(i);
      wb_data  = DW'(32'h100 + i);
      cyc();
      chk("stream_count_le1", 64'(count <= 1), 64'(1));
    end
    wb_valid = 1'b0;
    repeat (2) cyc();
    chk("stream_empty", 64'(exp_q.size()), 64'(0));

    // Reset between edges discards pending writes
    drain_en        = 1'b0;
    read_reg_a_addr = 5'd11;
    push(5'd11, 32'hA);
    push(5'd12, 32'hB);
    push(5'd13, 32'hC);
    drain_en = 1'b1;
    reset    = 1'b1;
    #1;
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_write_en", 64'(write_en), 64'(0));
    chk("midrst_wb_ready", 64'(wb_ready), 64'(1));
    exp_q.delete();
    #1;
    reset = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
